// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch-side branch redirect controller.
package branch_redirect_ctrl_pkg;

  localparam int unsigned PC_W = 32;
  localparam int unsigned STAT_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int unsigned FETCH_BYTES_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } state_e;

endpackage

// File: rtl/branch_redirect_ctrl_redirect_stat.sv
// Saturating event counters for applied branch redirects and delay-slot wait cycles.
module branch_redirect_ctrl_redirect_stat
  import branch_redirect_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_inc,
  input  logic              ds_wait_inc,
  output logic [STAT_W-1:0] stat_redirects,
  output logic [STAT_W-1:0] stat_ds_wait
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_redirects <= '0;
      stat_ds_wait   <= '0;
    end else begin
      if (redirect_inc && (stat_redirects != '1)) stat_redirects <= stat_redirects + STAT_W'(1);
      if (ds_wait_inc && (stat_ds_wait != '1))    stat_ds_wait   <= stat_ds_wait + STAT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC owner: applies ID branch redirects after the MIPS delay slot is fetched.
// Optional statistics counters are enabled with the REDIRECT_STAT_EN macro.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     FETCH_BYTES = FETCH_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            id_fire,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            ds_fetched,
  input  logic            flush_ex,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            fetch_ack,
  output logic            fetch_req,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fb_flush,
`ifdef REDIRECT_STAT_EN
  output logic [STAT_W-1:0] stat_redirects,
  output logic [STAT_W-1:0] stat_ds_wait,
`endif
  output logic            redirect_pending
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] target_q;
  logic [PC_W-1:0] pc_inc;
  logic            req_q;
  logic            br_fire;

  assign br_fire          = id_fire & br_taken;
  assign pc_inc           = pc_q + PC_W'(FETCH_BYTES);
  assign fetch_pc         = pc_q;
  assign fetch_req        = req_q;
  assign redirect_pending = (state_q == WAIT_DS);
  // Same-cycle kill of wrong-path fetches; an exception flush handles its own buffer kill.
  assign fb_flush         = (state_q == IDLE) & ~flush_ex & br_fire & ds_fetched;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      target_q <= '0;
      req_q    <= 1'b0;
    end else begin
      req_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush_ex) begin
            pc_q <= flush_pc;
          end else if (br_fire && ds_fetched) begin
            pc_q <= br_target;
          end else begin
            if (br_fire) begin
              target_q <= br_target;
              state_q  <= WAIT_DS;
            end
            if (fetch_ack) pc_q <= pc_inc;
          end
        end
        WAIT_DS: begin
          // The next accepted fetch is the delay slot; redirect right after it.
          if (flush_ex) begin
            pc_q     <= flush_pc;
            target_q <= '0;
            state_q  <= IDLE;
          end else if (fetch_ack) begin
            pc_q    <= target_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REDIRECT_STAT_EN
  logic redirect_inc;
  logic ds_wait_inc;

  assign redirect_inc = ~flush_ex &
                        (((state_q == IDLE) & br_fire & ds_fetched) |
                         ((state_q == WAIT_DS) & fetch_ack));
  assign ds_wait_inc  = ~flush_ex & (state_q == WAIT_DS);

  branch_redirect_ctrl_redirect_stat u_stat (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_inc   (redirect_inc),
    .ds_wait_inc    (ds_wait_inc),
    .stat_redirects (stat_redirects),
    .stat_ds_wait   (stat_ds_wait)
  );
`endif

`ifndef SYNTHESIS
  // A second taken branch cannot reach ID before the pending delay slot has.
  a_no_branch_in_wait_ds: assert property (@(posedge clk) disable iff (!resetn)
    !((state_q == WAIT_DS) && br_fire));
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_fire;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_fetched;
  logic        flush_ex;
  logic [31:0] flush_pc;
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fb_flush;
  logic        redirect_pending;
`ifdef REDIRECT_STAT_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_ds_wait;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .id_fire          (id_fire),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .ds_fetched       (ds_fetched),
    .flush_ex         (flush_ex),
    .flush_pc         (flush_pc),
    .fetch_ack        (fetch_ack),
    .fetch_req        (fetch_req),
    .fetch_pc         (fetch_pc),
    .fb_flush         (fb_flush),
`ifdef REDIRECT_STAT_EN
    .stat_redirects   (stat_redirects),
    .stat_ds_wait     (stat_ds_wait),
`endif
    .redirect_pending (redirect_pending)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_fire    = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    ds_fetched = 1'b0;
    flush_ex   = 1'b0;
    flush_pc   = 32'h0;
    fetch_ack  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", fetch_pc, 32'hBFC0_0000); end
    n_checks++;
    if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", fetch_req); end
    n_checks++;
    if (redirect_pending !== 1'b0 || fb_flush !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: pending %b flush %b want 0 0", redirect_pending, fb_flush);
    end
    resetn    = 1'b1;
    fetch_ack = 1'b0;
    step();
    n_checks++;
    if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL req_after_reset: got %b want 1", fetch_req); end
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL pc_hold_no_ack: got %h want %h", fetch_pc, 32'hBFC0_0000); end
    fetch_ack = 1'b1;
    step();
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0004) begin n_fail++; $display("FAIL seq_pc0: got %h want %h", fetch_pc, 32'hBFC0_0004); end
    step();
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0008) begin n_fail++; $display("FAIL seq_pc1: got %h want %h", fetch_pc, 32'hBFC0_0008); end
  endtask

  task automatic test_immediate_redirect();
    step();
    step();
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0010) begin n_fail++; $display("FAIL imm_setup_pc: got %h want %h", fetch_pc, 32'hBFC0_0010); end
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b1; br_target = 32'h8000_1000; fetch_ack = 1'b1;
    #1;
    n_checks++;
    if (fb_flush !== 1'b1) begin n_fail++; $display("FAIL imm_fb_flush: got %b want 1", fb_flush); end
    step();
    clear_inputs();
    #1;
    n_checks++;
    if (fetch_pc !== 32'h8000_1000) begin n_fail++; $display("FAIL imm_target: got %h want %h", fetch_pc, 32'h8000_1000); end
    n_checks++;
    if (fb_flush !== 1'b0 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL imm_after: flush %b pending %b want 0 0", fb_flush, redirect_pending);
    end
  endtask

  task automatic test_ds_wait();
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b0; br_target = 32'h8000_2000; fetch_ack = 1'b0;
    #1;
    n_checks++;
    if (fb_flush !== 1'b0) begin n_fail++; $display("FAIL ds_capture_flush: got %b want 0", fb_flush); end
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (redirect_pending !== 1'b1 || fetch_pc !== 32'h8000_1000 || fb_flush !== 1'b0) begin
        n_fail++;
        $display("FAIL ds_wait_%0d: pending %b pc %h flush %b want 1 %h 0",
                 i, redirect_pending, fetch_pc, fb_flush, 32'h8000_1000);
      end
      if (i < 2) step();
    end
    fetch_ack = 1'b1;
    #1;
    n_checks++;
    if (fb_flush !== 1'b0) begin n_fail++; $display("FAIL ds_complete_flush: got %b want 0", fb_flush); end
    step();
    n_checks++;
    if (fetch_pc !== 32'h8000_2000 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL ds_complete: pc %h pending %b want %h 0", fetch_pc, redirect_pending, 32'h8000_2000);
    end
  endtask

  task automatic test_back_to_back();
    // Capture with a concurrent accept: PC advances, then the delay-slot accept redirects.
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b0; br_target = 32'h8000_3000; fetch_ack = 1'b1;
    step();
    id_fire = 1'b0; br_taken = 1'b0;
    n_checks++;
    if (fetch_pc !== 32'h8000_2004 || redirect_pending !== 1'b1) begin
      n_fail++; $display("FAIL b2b_capture: pc %h pending %b want %h 1", fetch_pc, redirect_pending, 32'h8000_2004);
    end
    step();
    n_checks++;
    if (fetch_pc !== 32'h8000_3000 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL b2b_redirect: pc %h pending %b want %h 0", fetch_pc, redirect_pending, 32'h8000_3000);
    end
    clear_inputs();
  endtask

  task automatic test_flush_priority();
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b0; br_target = 32'h8000_4000; fetch_ack = 1'b0;
    step();
    clear_inputs();
    flush_ex = 1'b1; flush_pc = 32'hBFC0_0380; fetch_ack = 1'b1;
    #1;
    n_checks++;
    if (fb_flush !== 1'b0 || redirect_pending !== 1'b1) begin
      n_fail++; $display("FAIL flush_wait_flags: flush %b pending %b want 0 1", fb_flush, redirect_pending);
    end
    step();
    flush_ex = 1'b0;
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0380 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_pc: pc %h pending %b want %h 0", fetch_pc, redirect_pending, 32'hBFC0_0380);
    end
    step();
    n_checks++;
    if (fetch_pc !== 32'hBFC0_0384) begin n_fail++; $display("FAIL flush_no_old_target: got %h want %h", fetch_pc, 32'hBFC0_0384); end
    // Flush in IDLE beats an immediate branch and a concurrent accept.
    flush_ex = 1'b1; flush_pc = 32'h8000_0180;
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b1; br_target = 32'h8000_5555; fetch_ack = 1'b1;
    #1;
    n_checks++;
    if (fb_flush !== 1'b0) begin n_fail++; $display("FAIL flush_idle_fb: got %b want 0", fb_flush); end
    step();
    clear_inputs();
    n_checks++;
    if (fetch_pc !== 32'h8000_0180 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_pc: pc %h pending %b want %h 0", fetch_pc, redirect_pending, 32'h8000_0180);
    end
  endtask

  task automatic test_stalled_id();
    logic [31:0] exp_pc;
`ifdef REDIRECT_STAT_EN
    logic [31:0] red0;
    red0 = stat_redirects;
`endif
    exp_pc = 32'h8000_0180;
    br_taken = 1'b1; id_fire = 1'b0; ds_fetched = 1'b0; br_target = 32'h8000_6000; fetch_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (redirect_pending !== 1'b0 || fetch_pc !== exp_pc) begin
        n_fail++; $display("FAIL stall_%0d: pending %b pc %h want 0 %h", i, redirect_pending, fetch_pc, exp_pc);
      end
    end
    id_fire = 1'b1; fetch_ack = 1'b0;
    step();
    id_fire = 1'b0; br_taken = 1'b0;
    n_checks++;
    if (redirect_pending !== 1'b1 || fetch_pc !== 32'h8000_0190) begin
      n_fail++; $display("FAIL stall_capture: pending %b pc %h want 1 %h", redirect_pending, fetch_pc, 32'h8000_0190);
    end
    fetch_ack = 1'b1;
    step();
    n_checks++;
    if (fetch_pc !== 32'h8000_6000) begin n_fail++; $display("FAIL stall_redirect: got %h want %h", fetch_pc, 32'h8000_6000); end
    step();
    n_checks++;
    if (fetch_pc !== 32'h8000_6004 || redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL stall_single: pc %h pending %b want %h 0", fetch_pc, redirect_pending, 32'h8000_6004);
    end
`ifdef REDIRECT_STAT_EN
    n_checks++;
    if (stat_redirects !== red0 + 32'd1) begin
      n_fail++; $display("FAIL stall_stat: got %0d want %0d", stat_redirects, red0 + 32'd1);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_wrap();
    flush_ex = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush_ex = 1'b0;
    n_checks++;
    if (fetch_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want %h", fetch_pc, 32'hFFFF_FFFC); end
    fetch_ack = 1'b1;
    step();
    n_checks++;
    if (fetch_pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", fetch_pc, 32'h0); end
    // Unaligned targets pass through untouched.
    id_fire = 1'b1; br_taken = 1'b1; ds_fetched = 1'b1; br_target = 32'h8000_0002;
    step();
    clear_inputs();
    n_checks++;
    if (fetch_pc !== 32'h8000_0002) begin n_fail++; $display("FAIL unaligned_target: got %h want %h", fetch_pc, 32'h8000_0002); end
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    #1;
    test_reset();
    test_immediate_redirect();
    test_ds_wait();
    test_back_to_back();
    test_flush_priority();
    test_stalled_id();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
